// File: rtl/instruction_stream_decoder.sv
// rtl/instruction_stream_decoder.sv - assembles opcode+argument byte streams into instructions queued for the executor
// Optional inter-byte timeout in the argument phase: INSTRUCTION_STREAM_DECODER_TIMEOUT_EN
module instruction_stream_decoder #(
    parameter int DATA_W         = 8,
    parameter int ARGS_MAX       = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW            = DATA_W * (ARGS_MAX + 1),
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ack,
    output logic [IW-1:0]     o_instruction,
    output logic              o_instruction_valid,
    input  logic              i_instruction_ready,
    output logic [CNT_W-1:0]  o_fifo_count,
    output logic              o_busy,
    output logic              o_error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (DATA_W < 2 || ARGS_MAX > 3 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("instruction_stream_decoder: illegal parameter set");
    end

    typedef enum logic {S_IDLE, S_ARGS} state_t;

    state_t            state_q;
    logic [IW-1:0]     instr_q;
    logic [1:0]        rem_q;
    logic [1:0]        idx_q;
    logic [IW-1:0]     fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              ack_q;
    logic              error_q;

    logic [1:0]        n_args;
    logic              over_args;
    logic              would_push;
    logic              full;
    logic              pop;
    logic              stall;
    logic              accept;
    logic              push;
    logic [IW-1:0]     instr_ins;
    logic [IW-1:0]     push_data;

    assign n_args     = i_data[DATA_W-1 -: 2];
    assign over_args  = int'(n_args) > ARGS_MAX;
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = (count_q != '0) && i_instruction_ready;
    assign would_push = (state_q == S_IDLE) ? (n_args == 2'd0) : (rem_q == 2'd1);
    // A simultaneous pop frees the slot, so a full queue only stalls without one.
    assign stall      = full && would_push && !pop;
    assign accept     = i_we && i_en && !stall;
    assign push       = accept && would_push;

    always_comb begin
        instr_ins = instr_q;
        instr_ins[DATA_W*(int'(idx_q)+1) +: DATA_W] = i_data;
        push_data = (state_q == S_IDLE) ? IW'(i_data) : instr_ins;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

`ifdef INSTRUCTION_STREAM_DECODER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;

    assign tmo_hit = (state_q == S_ARGS) && !accept && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || state_q != S_ARGS || accept) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            error_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            ack_q   <= accept;
            count_q <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        instr_q <= IW'(i_data);
                        rem_q   <= n_args;
                        idx_q   <= '0;
                        if (over_args) begin
                            error_q <= 1'b1;
                        end else if (n_args != 2'd0) begin
                            state_q <= S_ARGS;
                        end
                    end
                end
                S_ARGS: begin
                    if (accept) begin
                        instr_q <= instr_ins;
                        rem_q   <= rem_q - 2'd1;
                        idx_q   <= idx_q + 2'd1;
                        if (rem_q == 2'd1) begin
                            state_q <= S_IDLE;
                        end
                    end else if (tmo_hit) begin
                        state_q <= S_IDLE;
                        error_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ack               = ack_q;
    assign o_instruction       = fifo_q[rd_ptr_q];
    assign o_instruction_valid = (count_q != '0);
    assign o_fifo_count        = count_q;
    assign o_busy              = (state_q == S_ARGS) || (count_q != '0);
    assign o_error             = error_q;

endmodule

// File: tb/tb_instruction_stream_decoder.sv
// tb/tb_instruction_stream_decoder.sv - scoreboard bench for instruction_stream_decoder (default and ARGS_MAX=1 instances)
`timescale 1ns/1ps
module tb_instruction_stream_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, we0, en0, rdy0;
    logic [7:0]  d0;
    logic        ack0, val0, busy0, err0;
    logic [31:0] ins0;
    logic [2:0]  cnt0;

    logic        rst1, we1, en1, rdy1;
    logic [7:0]  d1;
    logic        ack1, val1, busy1, err1;
    logic [15:0] ins1;
    logic [2:0]  cnt1;

    instruction_stream_decoder #(.DATA_W(8), .ARGS_MAX(3), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(1024)) u_dut0 (
        .i_clk(clk), .i_reset(rst0), .i_we(we0), .i_en(en0), .i_data(d0),
        .o_ack(ack0), .o_instruction(ins0), .o_instruction_valid(val0),
        .i_instruction_ready(rdy0), .o_fifo_count(cnt0), .o_busy(busy0), .o_error(err0)
    );

    instruction_stream_decoder #(.DATA_W(8), .ARGS_MAX(1), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) u_dut1 (
        .i_clk(clk), .i_reset(rst1), .i_we(we1), .i_en(en1), .i_data(d1),
        .o_ack(ack1), .o_instruction(ins1), .o_instruction_valid(val1),
        .i_instruction_ready(rdy1), .o_fifo_count(cnt1), .o_busy(busy1), .o_error(err1)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic        got;

    task automatic send(input int sel, input logic [7:0] b, input int tries, output logic acked);
        acked = 1'b0;
        if (sel == 0) begin we0 = 1'b1; en0 = 1'b1; d0 = b; end
        else          begin we1 = 1'b1; en1 = 1'b1; d1 = b; end
        for (int i = 0; i < tries && !acked; i++) begin
            @(posedge clk); #1;
            acked = (sel == 0) ? ack0 : ack1;
        end
        if (sel == 0) begin we0 = 1'b0; en0 = 1'b0; end
        else          begin we1 = 1'b0; en1 = 1'b0; end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ack0, val0, busy0, err0, cnt0, ins0} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut0 got ack=%b val=%b busy=%b err=%b cnt=%0d ins=%h, need all 0",
                     ack0, val0, busy0, err0, cnt0, ins0);
        end
        n_checks++;
        if ({ack1, val1, busy1, err1, cnt1, ins1} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut1 got ack=%b val=%b busy=%b err=%b cnt=%0d ins=%h, need all 0",
                     ack1, val1, busy1, err1, cnt1, ins1);
        end
        rst0 = 1'b0; rst1 = 1'b0;
    endtask

    task automatic test_zero_arg();
        rdy0 = 1'b1;
        send(0, 8'h05, 1, got);
        exp_q.push_back(32'h0000_0005);
        n_checks++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL zero_ack got %b need 1", got); end
        n_checks++;
        if (val0 !== 1'b1 || cnt0 !== 3'd1) begin
            n_fail++; $display("FAIL zero_valid got val=%b cnt=%0d need val=1 cnt=1", val0, cnt0);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (ins0 !== exp) begin n_fail++; $display("FAIL zero_instr got %h need %h", ins0, exp); end
        @(posedge clk); #1;
        rdy0 = 1'b0;
        n_checks++;
        if ({val0, busy0, ack0, cnt0} !== '0) begin
            n_fail++;
            $display("FAIL zero_popped got val=%b busy=%b ack=%b cnt=%0d need all 0", val0, busy0, ack0, cnt0);
        end
    endtask

    task automatic test_three_arg();
        logic [7:0] bytes [4];
        bytes = '{8'hC1, 8'h11, 8'h22, 8'h33};
        rdy0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(0, bytes[i], 1, got);
            n_checks++;
            if (got !== 1'b1) begin n_fail++; $display("FAIL three_ack byte%0d got %b need 1", i, got); end
            n_checks++;
            if (i < 3 && (cnt0 !== 3'd0 || busy0 !== 1'b1)) begin
                n_fail++; $display("FAIL three_early byte%0d got cnt=%0d busy=%b need cnt=0 busy=1", i, cnt0, busy0);
            end else if (i == 3 && (cnt0 !== 3'd1 || val0 !== 1'b1 || busy0 !== 1'b1)) begin
                n_fail++; $display("FAIL three_push got cnt=%0d val=%b busy=%b need 1 1 1", cnt0, val0, busy0);
            end
        end
        exp_q.push_back({bytes[3], bytes[2], bytes[1], bytes[0]});
        rdy0 = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (val0) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (ins0 !== exp) begin n_fail++; $display("FAIL three_instr got %h need %h", ins0, exp); end
            end
        end
        @(posedge clk); #1;
        rdy0 = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || busy0 !== 1'b0 || cnt0 !== 3'd0) begin
            n_fail++; $display("FAIL three_drain got left=%0d busy=%b cnt=%0d need 0 0 0", exp_q.size(), busy0, cnt0);
        end
    endtask

    task automatic test_back_pressure();
        rdy0 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(0, 8'(i), 1, got);
            exp_q.push_back(32'(i));
            n_checks++;
            if (got !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ack op%0d got %b need 1", i, got); end
        end
        n_checks++;
        if (cnt0 !== 3'd4) begin n_fail++; $display("FAIL bp_full_count got %0d need 4", cnt0); end
        we0 = 1'b1; en0 = 1'b1; d0 = 8'h05;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ack0 !== 1'b0 || cnt0 !== 3'd4) begin
            n_fail++; $display("FAIL bp_stall got ack=%b cnt=%0d need ack=0 cnt=4", ack0, cnt0);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (ins0 !== exp) begin n_fail++; $display("FAIL bp_head_hold got %h need %h", ins0, exp); end
        rdy0 = 1'b1;
        @(posedge clk); #1;
        rdy0 = 1'b0; we0 = 1'b0; en0 = 1'b0;
        exp_q.push_back(32'h0000_0005);
        n_checks++;
        if (ack0 !== 1'b1 || cnt0 !== 3'd4) begin
            n_fail++; $display("FAIL bp_push_pop got ack=%b cnt=%0d need ack=1 cnt=4", ack0, cnt0);
        end
        rdy0 = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (val0) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (ins0 !== exp) begin n_fail++; $display("FAIL bp_order got %h need %h", ins0, exp); end
            end
        end
        @(posedge clk); #1;
        rdy0 = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || cnt0 !== 3'd0) begin
            n_fail++; $display("FAIL bp_drain got left=%0d cnt=%0d need 0 0", exp_q.size(), cnt0);
        end
    endtask

    task automatic test_overflow_args();
        rdy1 = 1'b0;
        send(1, 8'h80, 1, got);
        n_checks++;
        if (got !== 1'b1 || err1 !== 1'b1 || cnt1 !== 3'd0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drop got ack=%b err=%b cnt=%0d busy=%b need 1 1 0 0", got, err1, cnt1, busy1);
        end
        send(1, 8'h41, 1, got);
        n_checks++;
        if (got !== 1'b1 || busy1 !== 1'b1 || cnt1 !== 3'd0) begin
            n_fail++; $display("FAIL ovf_opcode got ack=%b busy=%b cnt=%0d need 1 1 0", got, busy1, cnt1);
        end
        send(1, 8'hAA, 1, got);
        exp_q.push_back(32'h0000_AA41);
        n_checks++;
        if (got !== 1'b1 || cnt1 !== 3'd1) begin
            n_fail++; $display("FAIL ovf_arg got ack=%b cnt=%0d need 1 1", got, cnt1);
        end
        rdy1 = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (val1) begin
                exp = exp_q.pop_front();
                n_checks++;
                if ({16'h0, ins1} !== exp) begin n_fail++; $display("FAIL ovf_instr got %h need %h", ins1, exp); end
            end
        end
        @(posedge clk); #1;
        rdy1 = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || err1 !== 1'b1 || cnt1 !== 3'd0) begin
            n_fail++; $display("FAIL ovf_sticky got left=%0d err=%b cnt=%0d need 0 1 0", exp_q.size(), err1, cnt1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bytes [4];
        bytes = '{8'h01, 8'h02, 8'hC0, 8'h01};
        rdy0 = 1'b0;
        for (int i = 0; i < 4; i++) send(0, bytes[i], 1, got);
        n_checks++;
        if (cnt0 !== 3'd2 || busy0 !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_setup got cnt=%0d busy=%b need 2 1", cnt0, busy0);
        end
        rst0 = 1'b1; we0 = 1'b1; en0 = 1'b1; d0 = 8'h07;
        @(posedge clk); #1;
        rst0 = 1'b0; we0 = 1'b0; en0 = 1'b0;
        exp_q.delete();
        n_checks++;
        if ({ack0, val0, busy0, cnt0} !== '0) begin
            n_fail++; $display("FAIL rstmid_clear got ack=%b val=%b busy=%b cnt=%0d need all 0", ack0, val0, busy0, cnt0);
        end
        send(0, 8'h02, 1, got);
        exp_q.push_back(32'h0000_0002);
        n_checks++;
        if (got !== 1'b1 || cnt0 !== 3'd1) begin
            n_fail++; $display("FAIL rstmid_fresh got ack=%b cnt=%0d need 1 1", got, cnt0);
        end
        rdy0 = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (val0) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (ins0 !== exp) begin n_fail++; $display("FAIL rstmid_instr got %h need %h", ins0, exp); end
            end
        end
        @(posedge clk); #1;
        rdy0 = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || cnt0 !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_drain got left=%0d cnt=%0d need 0 0", exp_q.size(), cnt0);
        end
    endtask

`ifdef INSTRUCTION_STREAM_DECODER_TIMEOUT_EN
    task automatic test_timeout();
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        n_checks++;
        if (err1 !== 1'b0) begin n_fail++; $display("FAIL tmo_reset_err got %b need 0", err1); end
        send(1, 8'h40, 1, got);
        repeat (15) @(posedge clk);
        #1;
        n_checks++;
        if (err1 !== 1'b0 || busy1 !== 1'b1) begin
            n_fail++; $display("FAIL tmo_early got err=%b busy=%b need 0 1", err1, busy1);
        end
        @(posedge clk); #1;
        n_checks++;
        if (err1 !== 1'b1 || busy1 !== 1'b0 || cnt1 !== 3'd0) begin
            n_fail++; $display("FAIL tmo_fire got err=%b busy=%b cnt=%0d need 1 0 0", err1, busy1, cnt1);
        end
        send(1, 8'h01, 1, got);
        n_checks++;
        if (got !== 1'b1 || cnt1 !== 3'd1 || ins1 !== 16'h0001) begin
            n_fail++; $display("FAIL tmo_idle got ack=%b cnt=%0d ins=%h need 1 1 0001", got, cnt1, ins1);
        end
        rdy1 = 1'b1;
        @(posedge clk); #1;
        rdy1 = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1; we0 = 1'b0; en0 = 1'b0; rdy0 = 1'b0; d0 = 8'h00;
        rst1 = 1'b1; we1 = 1'b0; en1 = 1'b0; rdy1 = 1'b0; d1 = 8'h00;
        test_reset();
        test_zero_arg();
        test_three_arg();
        test_back_pressure();
        test_overflow_args();
        test_reset_mid();
`ifdef INSTRUCTION_STREAM_DECODER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
